// File: rtl/db_key_extract_if.sv
// Receive-stream tap bundle between the 10G MAC and the key extractor.
// There is no tready: the consumer is a passive tap and never backpressures.
interface db_key_extract_if;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;

    modport master (output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast);
    modport slave  (input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast);
endinterface

// File: rtl/db_key_extract.sv
// Passive IPv4/UDP flow-key parser on the clk156 MAC receive stream.
// Emits {src_ip, dst_ip, dport, 16'h0} one cycle after the fifth beat, with frame/key/drop stats.
module db_key_extract #(
    parameter int          KEY_SIZE    = 96,
    parameter logic [15:0] INSERT_PORT = 16'd53,
    parameter logic [3:0]  FLAG_LOOKUP = 4'b0001,
    parameter logic [3:0]  FLAG_INSERT = 4'b0010
) (
    input  logic                clk,
    input  logic                rst,
    db_key_extract_if.slave     rx,
    output logic [KEY_SIZE-1:0] out_key,
    output logic [3:0]          out_flag,
    output logic                out_valid,
    output logic [31:0]         stat_frame_cnt,
    output logic [31:0]         stat_key_cnt,
    output logic [31:0]         stat_drop_cnt
);

    typedef enum logic [2:0] {IDLE, B1, B2, B3, B4, SKIP} state_t;

    state_t             state_q, state_d;
    logic               bad_q, bad_d;
    logic [31:0]        src_ip_q, src_ip_d;
    logic [15:0]        dst_hi_q, dst_hi_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [3:0]         flag_q, flag_d;
    logic               vld_q;
    logic [31:0]        frame_cnt_q, key_cnt_q, drop_cnt_q;
    logic               emit, drop, beat, last;
    logic [15:0]        dport;
    logic               unused_keep;

    assign beat        = rx.s_axis_tvalid;
    assign last        = rx.s_axis_tvalid & rx.s_axis_tlast;
    assign dport       = {rx.s_axis_tdata[39:32], rx.s_axis_tdata[47:40]};
    assign unused_keep = ^{rx.s_axis_tkeep[7:6], rx.s_axis_tkeep[4:0]};

    always_comb begin
        state_d  = state_q;
        bad_d    = bad_q;
        src_ip_d = src_ip_q;
        dst_hi_d = dst_hi_q;
        key_d    = key_q;
        flag_d   = flag_q;
        emit     = 1'b0;
        drop     = 1'b0;
        if (beat) begin
            case (state_q)
                IDLE: begin
                    // Beat 0 only carries MACs; a tlast here is a 1-beat runt.
                    bad_d = 1'b0;
                    if (last) drop = 1'b1;
                    else      state_d = B1;
                end
                B1: begin
                    if ({rx.s_axis_tdata[39:32], rx.s_axis_tdata[47:40]} != 16'h0800 ||
                        rx.s_axis_tdata[55:48] != 8'h45)
                        bad_d = 1'b1;
                    if (last) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = B2;
                    end
                end
                B2: begin
                    if (rx.s_axis_tdata[63:56] != 8'd17) bad_d = 1'b1;
                    if (last) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = B3;
                    end
                end
                B3: begin
                    src_ip_d = {rx.s_axis_tdata[23:16], rx.s_axis_tdata[31:24],
                                rx.s_axis_tdata[39:32], rx.s_axis_tdata[47:40]};
                    dst_hi_d = {rx.s_axis_tdata[55:48], rx.s_axis_tdata[63:56]};
                    if (last) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = B4;
                    end
                end
                B4: begin
                    // Key is complete here; emission does not wait for tlast.
                    if (bad_q || !rx.s_axis_tkeep[5]) begin
                        bad_d = 1'b1;
                        drop  = last;
                    end else begin
                        emit   = 1'b1;
                        key_d  = {src_ip_q, dst_hi_q, rx.s_axis_tdata[7:0],
                                  rx.s_axis_tdata[15:8], dport, 16'h0000};
                        flag_d = (dport == INSERT_PORT) ? FLAG_INSERT : FLAG_LOOKUP;
                    end
                    state_d = last ? IDLE : SKIP;
                end
                SKIP: begin
                    if (last) begin
                        drop    = bad_q;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bad_q       <= 1'b0;
            src_ip_q    <= '0;
            dst_hi_q    <= '0;
            key_q       <= '0;
            flag_q      <= '0;
            vld_q       <= 1'b0;
            frame_cnt_q <= '0;
            key_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bad_q       <= bad_d;
            src_ip_q    <= src_ip_d;
            dst_hi_q    <= dst_hi_d;
            key_q       <= key_d;
            flag_q      <= flag_d;
            vld_q       <= emit;
            frame_cnt_q <= frame_cnt_q + {31'd0, last};
            key_cnt_q   <= key_cnt_q + {31'd0, emit};
            drop_cnt_q  <= drop_cnt_q + {31'd0, drop};
        end
    end

    assign out_key        = key_q;
    assign out_flag       = flag_q;
    assign out_valid      = vld_q;
    assign stat_frame_cnt = frame_cnt_q;
    assign stat_key_cnt   = key_cnt_q;
    assign stat_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_db_key_extract.sv
// Directed bench for db_key_extract: hand-built IPv4/UDP/ARP/TCP frames with expected keys and stats.
module tb_db_key_extract;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] out_key;
    logic [3:0]  out_flag;
    logic        out_valid;
    logic [31:0] stat_frame_cnt, stat_key_cnt, stat_drop_cnt;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;
    int vbase;

    logic [63:0] fr [8];

    db_key_extract_if rx ();

    db_key_extract dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx.slave),
        .out_key        (out_key),
        .out_flag       (out_flag),
        .out_valid      (out_valid),
        .stat_frame_cnt (stat_frame_cnt),
        .stat_key_cnt   (stat_key_cnt),
        .stat_drop_cnt  (stat_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [15:0] eth, input logic [7:0] vihl, input logic [7:0] proto,
                               input logic [31:0] src, input logic [31:0] dst, input logic [15:0] dp);
        fr[0] = 64'h1122334455667788;
        fr[1] = {8'h00, vihl, eth[7:0], eth[15:8], 32'hAABBCCDD};
        fr[2] = {proto, 8'h40, 32'h0000_0000, 16'h2E00};
        fr[3] = {dst[23:16], dst[31:24], src[7:0], src[15:8], src[23:16], src[31:24], 16'h0000};
        fr[4] = {8'h10, 8'h00, dp[7:0], dp[15:8], 8'h35, 8'h12, dst[7:0], dst[15:8]};
        fr[5] = 64'hDEADBEEF_CAFEF00D;
        fr[6] = 64'h0123456789ABCDEF;
        fr[7] = 64'hFFFF_0000_FFFF_0000;
    endtask

    // Drives beats at negedge; out_valid is sampled at the negedge following the B4 edge.
    task automatic send_frame(input int n, input bit last_on_end, input int gap_at, input int gap_len,
                              input logic [7:0] keep4, input bit exp_emit,
                              input logic [95:0] ek, input logic [3:0] ef);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                rx.s_axis_tvalid = 1'b0;
                rx.s_axis_tlast  = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            rx.s_axis_tdata  = fr[i];
            rx.s_axis_tkeep  = (i == 4) ? keep4 : 8'hFF;
            rx.s_axis_tvalid = 1'b1;
            rx.s_axis_tlast  = last_on_end && (i == n - 1);
            @(negedge clk);
            if (i == 4) begin
                check("valid_after_b4", {95'd0, out_valid}, {95'd0, exp_emit});
                if (exp_emit) begin
                    check("key", out_key, ek);
                    check("flag", {92'd0, out_flag}, {92'd0, ef});
                end
            end
            if (i == 5 && exp_emit) check("pulse_width", {95'd0, out_valid}, 96'd0);
        end
        rx.s_axis_tvalid = 1'b0;
        rx.s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int f, input int k, input int d);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_frame"}, {64'd0, stat_frame_cnt}, f);
        check({tag, "_key"},   {64'd0, stat_key_cnt},   k);
        check({tag, "_drop"},  {64'd0, stat_drop_cnt},  d);
    endtask

    localparam logic [95:0] K1 = 96'h0A000001_0A000002_1F90_0000;
    localparam logic [95:0] K2 = 96'h0A000001_0A000002_0035_0000;

    initial begin
        rx.s_axis_tdata  = '0;
        rx.s_axis_tkeep  = '0;
        rx.s_axis_tvalid = 1'b0;
        rx.s_axis_tlast  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {95'd0, out_valid}, 96'd0);
        check("rst_key", out_key, 96'd0);
        check("rst_flag", {92'd0, out_flag}, 96'd0);
        check("rst_cnts", {stat_frame_cnt, stat_key_cnt, stat_drop_cnt}, 96'd0);
        rst = 1'b0;

        // Gapless good frame
        build_frame(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h1F90);
        send_frame(8, 1, -1, 0, 8'hFF, 1, K1, 4'b0001);
        check_stats("t1", 1, 1, 0);

        // INSERT port with a 3-cycle tvalid gap between beats 2 and 3
        build_frame(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd53);
        vbase = vcount;
        send_frame(8, 1, 3, 3, 8'hFF, 1, K2, 4'b0010);
        check_stats("t2", 2, 2, 0);
        check("t2_pulses", vcount - vbase, 1);

        // ARP, TCP, IHL=6, then a UDP frame whose B4 lacks byte 5
        do_reset();
        vbase = vcount;
        build_frame(16'h0806, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h1F90);
        send_frame(8, 1, -1, 0, 8'hFF, 0, '0, '0);
        build_frame(16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'h1F90);
        send_frame(8, 1, -1, 0, 8'hFF, 0, '0, '0);
        build_frame(16'h0800, 8'h46, 8'd17, 32'h0A000001, 32'h0A000002, 16'h1F90);
        send_frame(8, 1, -1, 0, 8'hFF, 0, '0, '0);
        check_stats("t3", 3, 0, 3);
        build_frame(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h1F90);
        send_frame(8, 1, -1, 0, 8'h1F, 0, '0, '0);
        check_stats("t3k", 4, 0, 4);
        check("t3_pulses", vcount - vbase, 0);

        // Truncated at beat 2, immediately followed by a good frame
        do_reset();
        build_frame(16'h0800, 8'h45, 8'd17, 32'hC0A80105, 32'h08080808, 16'h0050);
        send_frame(3, 1, -1, 0, 8'hFF, 0, '0, '0);
        send_frame(8, 1, -1, 0, 8'hFF, 1, 96'hC0A80105_08080808_0050_0000, 4'b0001);
        check_stats("t4", 2, 1, 1);

        // Reset during beat 3 aborts the frame
        vbase = vcount;
        build_frame(16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h1F90);
        send_frame(3, 0, -1, 0, 8'hFF, 0, '0, '0);
        rx.s_axis_tdata  = fr[3];
        rx.s_axis_tkeep  = 8'hFF;
        rx.s_axis_tvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx.s_axis_tvalid = 1'b0;
        check_stats("t5rst", 0, 0, 0);
        check("t5_abort_pulses", vcount - vbase, 0);
        send_frame(8, 1, -1, 0, 8'hFF, 1, K1, 4'b0001);
        check_stats("t5", 1, 1, 0);

        // key counter wrap
        force dut.key_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.key_cnt_q;
        @(negedge clk);
        check("t6_preload", {64'd0, stat_key_cnt}, {64'd0, 32'hFFFF_FFFF});
        send_frame(8, 1, -1, 0, 8'hFF, 1, K1, 4'b0001);
        @(negedge clk);
        check("t6_wrap", {64'd0, stat_key_cnt}, 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/db_key_extract.md
Name: db_key_extract

Overview:
- Passive parser that sits directly upstream of the DB lookup top (db_top).
- Taps the 64-bit receive stream from the 10G MAC in the clk156 domain and extracts the 96-bit flow key {src IP, dst IP, dst UDP port, 16'h0} from IPv4/UDP frames.
- Emits the key with a one-cycle valid pulse and a 4-bit op flag, ready to drive db_top in_key/in_flag/in_valid.
- Keeps frame, key and drop statistics counters.

Parameters:
- KEY_SIZE, 96, output key width; fixed layout, must be 96.
- INSERT_PORT, 16'd53, UDP dst port that marks a frame as INSERT instead of LOOKUP.
- FLAG_LOOKUP, 4'b0001, out_flag value for ordinary frames.
- FLAG_INSERT, 4'b0010, out_flag value when dst port == INSERT_PORT.

Ports:
- clk  in  1  clk156, the only clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  64  stream data; byte n of the beat is on [8n+7:8n].
- s_axis_tkeep  in  8  byte enables.
- s_axis_tvalid  in  1  beat valid. There is no tready; the tap never backpressures.
- s_axis_tlast  in  1  last beat of frame.
- out_key  out  KEY_SIZE  extracted key.
- out_flag  out  4  op flag.
- out_valid  out  1  single-cycle key strobe.
- stat_frame_cnt  out  32  frames seen (counted on each tlast beat).
- stat_key_cnt  out  32  keys emitted.
- stat_drop_cnt  out  32  frames rejected (non-IPv4, IHL!=5, non-UDP, or truncated).

Behaviour:
- Reset: all outputs are 0, state = IDLE, all counters = 0. Reset mid-frame aborts the frame with no output. The next beat after reset is treated as beat 0, because rst is shared with the MAC.
- Only cycles with tvalid=1 are beats. tvalid gaps hold state and captured fields unchanged.
- FSM states: IDLE (expecting beat0), B1, B2, B3, B4, SKIP.
- IDLE -> B1 on any beat; beat0 content (MACs) is ignored.
- B1 checks:
  - ethertype = {tdata[39:32], tdata[47:40]} must equal 16'h0800.
  - tdata[55:48] must equal 8'h45.
- B2 checks: protocol = tdata[63:56] must equal 8'd17.
- B3 captures:
  - src_ip = {b2, b3, b4, b5}.
  - dst_ip[31:16] = {b6, b7}.
- B4 captures:
  - dst_ip[15:0] = {b0, b1}.
  - dport = {b4, b5}.
  - Requires tkeep[5]=1.
- Any failed check marks the frame bad; the FSM continues to SKIP without emitting.
- After B4, go to SKIP, or to IDLE if tlast is set on B4.
- SKIP -> IDLE on a tlast beat.
- tlast in B1..B3 (or tlast in IDLE as a 1-beat frame): frame is truncated. Increment drop, return to IDLE, emit nothing.
- Emission: a good frame asserts out_valid exactly 1 cycle after the B4 beat, for exactly 1 cycle.
  - out_key = {src_ip, dst_ip, dport, 16'h0000}.
  - out_flag = (dport == INSERT_PORT) ? FLAG_INSERT : FLAG_LOOKUP.
  - stat_key_cnt increments on the same cycle.
- out_key and out_flag hold their last value while out_valid=0.
- Emission does not wait for tlast; the rest of the frame does not affect an already-emitted key.
- stat_drop_cnt increments once per rejected frame, at the cycle after the tlast beat.
- Counters are 32-bit and wrap at 2^32-1 -> 0.
- Simultaneous events in one cycle (e.g. key emit plus frame count) are all applied.
- Minimum inter-key spacing is 5 cycles, so downstream needs no buffering.

Test Plan:
- Back-to-back good frame, no gaps, IPv4/UDP, src 10.0.0.1, dst 10.0.0.2, dport 0x1F90, 8 beats -> out_valid one cycle after beat4; out_key = 96'h0A000001_0A000002_1F90_0000; out_flag = 4'b0001; key_cnt = 1, frame_cnt = 1, drop_cnt = 0.
- Same frame with dport = 53 and tvalid low for 3 cycles between beats 2 and 3 -> out_flag = 4'b0010; pulse still exactly 1 cycle, after beat4; captured key correct.
- ARP frame (ethertype 0x0806), then TCP frame (protocol 6), then IHL=6 frame -> no out_valid; drop_cnt = 3, frame_cnt = 3.
- Truncated frame with tlast on beat2, immediately followed by a good frame -> first dropped (drop_cnt = 1), second emits the correct key; FSM realigned.
- rst asserted for 1 cycle during beat3 of a good frame, then a good frame -> no emission for the aborted frame, counters = 0, next frame key emitted, key_cnt = 1.
- Preload key_cnt to 32'hFFFFFFFF via force, then send 1 good frame -> key_cnt = 0.
